// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives columns, synchronises and debounces rows,
// and emits one KEY_PRESS strobe with ITEM_CODE per debounced key press.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] ROW,
    output logic [3:0] COL,
    output logic [3:0] ITEM_CODE,
    output logic       KEY_PRESS,
    output logic       KEY_HELD,
    output logic       MULTI_KEY
);

    localparam int DW  = $clog2(SCAN_DIV) + 1;
    localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DCW-1:0] DEB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t         state, next_state;
    logic [3:0]     row_meta, rs;
    logic [DW-1:0]  dwell;
    logic [DCW-1:0] deb_cnt;
    logic [1:0]     col;
    logic [3:0]     cand;

    logic [3:0] row_low;
    logic       none_low, one_low, sample, match, deb_done;
    logic       advance, accept, multi, release_done;
    logic [3:0] key_code;

    function automatic logic [3:0] encode(input logic [3:0] pat, input logic [1:0] c);
        logic [1:0] r;
        r = 2'd0;
        for (int unsigned i = 0; i < 4; i++)
            if (!pat[i]) r = 2'(i);
        case ({r, c})
            4'h0: encode = 4'd1;   4'h1: encode = 4'd2;   4'h2: encode = 4'd3;   4'h3: encode = 4'd10;
            4'h4: encode = 4'd4;   4'h5: encode = 4'd5;   4'h6: encode = 4'd6;   4'h7: encode = 4'd11;
            4'h8: encode = 4'd7;   4'h9: encode = 4'd8;   4'hA: encode = 4'd9;   4'hB: encode = 4'd12;
            4'hC: encode = 4'd14;  4'hD: encode = 4'd0;   4'hE: encode = 4'd15;  default: encode = 4'd13;
        endcase
    endfunction

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= SCAN;
        else          state <= next_state;
    end

    always_comb begin
        row_low  = ~rs;
        none_low = (rs == 4'hF);
        one_low  = !none_low && ((row_low & (row_low - 4'd1)) == '0);
        sample   = (dwell == DWELL_LAST);
        match    = (rs == cand);
        deb_done = (deb_cnt == DEB_LAST);

        next_state = state;
        case (state)
            SCAN:     if (sample && one_low) next_state = DEBOUNCE;
            DEBOUNCE: if (!match)            next_state = SCAN;
                      else if (deb_done)     next_state = HELD;
            HELD:     if (none_low)          next_state = RELEASE;
            RELEASE:  if (!none_low)         next_state = HELD;
                      else if (deb_done)     next_state = SCAN;
            default:                         next_state = SCAN;
        endcase
    end

    always_comb begin
        COL          = ~(4'b0001 << col);
        multi        = (state == SCAN) && sample && !none_low && !one_low;
        accept       = (state == DEBOUNCE) && match && deb_done;
        release_done = (state == RELEASE) && none_low && deb_done;
        advance      = ((state == SCAN) && sample && !one_low) ||
                       ((state == DEBOUNCE) && !match) || release_done;
        key_code     = encode(cand, col);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            row_meta  <= '1;
            rs        <= '1;
            dwell     <= '0;
            deb_cnt   <= '0;
            col       <= '0;
            cand      <= '1;
            ITEM_CODE <= '0;
            KEY_PRESS <= 1'b0;
            KEY_HELD  <= 1'b0;
            MULTI_KEY <= 1'b0;
        end else begin
            row_meta <= ROW;
            rs       <= row_meta;

            if (state == SCAN && !sample) dwell <= dwell + 1'b1;
            else                          dwell <= '0;

            // One counter serves both the press and release debounce; it restarts on any break
            if (((state == DEBOUNCE && match) || (state == RELEASE && none_low)) && !deb_done)
                deb_cnt <= deb_cnt + 1'b1;
            else
                deb_cnt <= '0;

            if (advance) col <= col + 2'd1;
            if (state == SCAN && sample && one_low) cand <= rs;

            KEY_PRESS <= accept;
            MULTI_KEY <= multi;
            if (accept) ITEM_CODE <= key_code;
            if (accept)            KEY_HELD <= 1'b1;
            else if (release_done) KEY_HELD <= 1'b0;
        end
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Front-end keypad stage for the vending machine. It scans a 4x4 matrix keypad, synchronises and debounces the row lines, and encodes the pressed key to a 4-bit code. For each debounced press it emits exactly one single-cycle KEY_PRESS strobe with ITEM_CODE, and it feeds the vending FSM's ITEM_CODE/KEY_PRESS inputs directly.

Parameters:
SCAN_DIV, 4, clock cycles each column is driven before advancing (>=2)
DEBOUNCE_CYCLES, 8, consecutive stable cycles required to accept a press or a release (>=1)

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
ROW  input  4  keypad row sense lines, active-low (pulled up externally), asynchronous to CLK
COL  output  4  column drive, active-low one-hot
ITEM_CODE  output  4  code of last accepted key, held until the next accepted key
KEY_PRESS  output  1  one-cycle strobe per accepted press
KEY_HELD  output  1  high from acceptance until a debounced release
MULTI_KEY  output  1  one-cycle strobe when more than one row is low in a sampled column

Behaviour:
- Reset (RESET_N low, asynchronous): COL=4'b1110 (column 0), ITEM_CODE=0, KEY_PRESS=0, KEY_HELD=0, MULTI_KEY=0, state=SCAN, all counters 0, synchroniser flops set to 4'b1111. All effects are immediate, including mid-debounce or mid-hold.
- ROW passes through a 2-flop synchroniser. Only the synchronised value (rs) is used.
- Key map as row,col -> code:
  - r0: 1,2,3,A -> 1,2,3,10
  - r1: 4,5,6,B -> 4,5,6,11
  - r2: 7,8,9,C -> 7,8,9,12
  - r3: *,0,#,D -> 14,0,15,13
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - The dwell counter counts 0..SCAN_DIV-1.
  - rs is sampled only when dwell==SCAN_DIV-1.
  - rs==4'b1111: advance to column (c+1) mod 4 (3 wraps to 0) and clear dwell.
  - Exactly one rs bit low: latch candidate row/col, go to DEBOUNCE, freeze COL, clear deb_cnt.
  - Two or more rs bits low: MULTI_KEY=1 for that cycle, advance column, no press.
- DEBOUNCE (COL frozen):
  - Each cycle rs equals the latched pattern: deb_cnt++.
  - Any mismatch: return to SCAN at the next column, no outputs.
  - On the cycle the count reaches DEBOUNCE_CYCLES: ITEM_CODE<=code and KEY_PRESS<=1 on the same edge (visible one cycle later for one cycle), KEY_HELD<=1, go to HELD.
- HELD (COL frozen): no auto-repeat, and other keys are ignored. When rs==4'b1111, go to RELEASE with deb_cnt cleared.
- RELEASE:
  - Count consecutive rs==4'b1111 cycles. Any low bit returns to HELD (no new strobe).
  - On reaching DEBOUNCE_CYCLES: KEY_HELD<=0, go to SCAN at the next column with dwell cleared.
- Latency: a clean press is accepted no earlier than 2 (sync) + DEBOUNCE_CYCLES cycles after the column sample, and at most 2 + 4*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles after ROW goes stable.
- KEY_PRESS and MULTI_KEY are never high in the same cycle. At most one KEY_PRESS occurs per physical press.
- Counter widths: $clog2 of the parameter + 1. No wrap occurs in any counter.

Test Plan:
- Reset then hold key '5' (ROW[1] low while COL[1] low) for 100 cycles with default parameters -> exactly one KEY_PRESS, ITEM_CODE=5, KEY_HELD=1. After release plus 8 stable cycles, KEY_HELD=0.
- Key '#' bounces: ROW[3] toggles every 3 cycles for 30 cycles, then stays low -> no strobe during bounce, then a single KEY_PRESS with ITEM_CODE=15. Separately, press '0' -> ITEM_CODE=0.
- Hold key 'A' for 2000 cycles -> a single KEY_PRESS (ITEM_CODE=10), no repeats, and COL stays 4'b0111 throughout the hold.
- '2' and '8' held together (same column) -> a MULTI_KEY pulse each scan of column 1, and no KEY_PRESS. ITEM_CODE keeps its previous value.
- Release glitch: after accepting '9', ROW goes high for 5 cycles, low for 1, then high -> still one press, and KEY_HELD falls only after 8 consecutive high cycles.
- Assert RESET_N low mid-DEBOUNCE (asynchronously, between edges) -> outputs are immediately ITEM_CODE=0, KEY_PRESS=0, KEY_HELD=0, COL=4'b1110. After deassertion, scanning restarts from column 0.
